// File: rtl/stickit_decode.sv
// stickit_decode
//   Snoops an 8-line charlieplexed 7-segment scan bus and rebuilds the
//   eight displayed hex digits. A digit is shown when exactly one line is
//   driven high (the select line); the remaining seven lines, in
//   ascending order, carry segments a..g as driven-low (lit) or Z (dark).
//
// Ports
//   CLK      in   1  sample clock, same domain as the scan driver
//   RESET_N  in   1  asynchronous active-low reset
//   S_OE     in   8  per-line drive enable (0 = line is Z)
//   S_IN     in   8  per-line driven level, meaningful where S_OE=1
//   VALUE    out 32  last complete frame, digit k at VALUE[4k+3:4k]
//   VALID    out  1  one-cycle pulse when VALUE updates
//   ERROR    out  1  one-cycle pulse when a frame is discarded
//   LOCKED   out  1  set by a good frame, cleared by error/timeout/reset
module stickit_decode #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  S_OE,
   input  logic [7:0]  S_IN,
   output logic [31:0] VALUE,
   output logic        VALID,
   output logic        ERROR,
   output logic        LOCKED
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      HUNT,
      COLLECT
   } state_t;

   state_t            state_q;
   logic [7:0]        oe_q;
   logic [7:0]        in_q;
   logic [2:0]        e_q;
   logic [3:0]        shadow_q [8];
   logic [IDLE_W-1:0] idle_q;
   logic [31:0]       value_q;
   logic              valid_q;
   logic              error_q;
   logic              locked_q;

   // bus decode of the registered sample
   logic [7:0] high;
   logic [7:0] low;
   logic       blank;
   logic       one_hot;
   logic       bus_err;
   logic [2:0] sel_k;
   logic [2:0] line;
   logic [6:0] seg;
   logic [3:0] nib;
   logic       code_ok;

   always_comb begin
      high    = oe_q & in_q;
      low     = oe_q & ~in_q;
      blank   = (high == '0);
      // clearing the lowest set bit leaves zero only for a single HIGH line
      one_hot = !blank && ((high & (high - 8'd1)) == '0);
      bus_err = !blank && !one_hot;

      sel_k = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (high[i]) sel_k = 3'(i);
      end

      // segment j lives on line j below the select line, line j+1 above it
      seg  = '0;
      line = '0;
      for (int unsigned j = 0; j < 7; j++) begin
         line   = (3'(j) >= sel_k) ? 3'(j + 1) : 3'(j);
         seg[j] = low[line];
      end

      code_ok = 1'b1;
      nib     = '0;
      case (seg)
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h6F: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         default: code_ok = 1'b0;
      endcase
   end

   // frame decisions, only acted on in COLLECT
   logic sample;
   logic in_order;
   logic repeat_ok;
   logic abort;

   always_comb begin
      sample    = one_hot && code_ok;
      in_order  = sample && (sel_k == e_q);
      repeat_ok = sample && (sel_k == e_q - 3'd1);
      abort     = bus_err
               || (one_hot && !code_ok)
               || (sample && !in_order && !repeat_ok)
               || (blank && (idle_q == IDLE_LAST));
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         oe_q     <= '0;
         in_q     <= '0;
         state_q  <= HUNT;
         e_q      <= '0;
         idle_q   <= '0;
         value_q  <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         locked_q <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         oe_q    <= S_OE;
         in_q    <= S_IN;
         valid_q <= 1'b0;
         error_q <= 1'b0;

         unique case (state_q)
            HUNT: begin
               idle_q <= '0;
               e_q    <= '0;
               // anything other than a clean digit 0 is silently skipped
               if (sample && (sel_k == 3'd0)) begin
                  shadow_q[0] <= nib;
                  e_q         <= 3'd1;
                  state_q     <= COLLECT;
               end
            end

            COLLECT: begin
               if (abort) begin
                  error_q  <= 1'b1;
                  locked_q <= 1'b0;
                  state_q  <= HUNT;
                  e_q      <= '0;
                  idle_q   <= '0;
               end else if (in_order) begin
                  idle_q          <= '0;
                  shadow_q[sel_k] <= nib;
                  if (e_q == 3'd7) begin
                     value_q  <= {nib, shadow_q[6], shadow_q[5], shadow_q[4],
                                  shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
                     valid_q  <= 1'b1;
                     locked_q <= 1'b1;
                     state_q  <= HUNT;
                     e_q      <= '0;
                  end else begin
                     e_q <= e_q + 3'd1;
                  end
               end else if (repeat_ok) begin
                  // slow scan shows the previous digit again
                  idle_q          <= '0;
                  shadow_q[sel_k] <= nib;
               end else if (idle_q != '1) begin
                  idle_q <= idle_q + 1'b1;
               end
            end

            default: state_q <= HUNT;
         endcase
      end
   end

   assign VALUE  = value_q;
   assign VALID  = valid_q;
   assign ERROR  = error_q;
   assign LOCKED = locked_q;

endmodule

// File: tb/tb_stickit_decode.sv
// tb_stickit_decode
//   Drives charlieplex scan patterns into stickit_decode and checks every
//   VALID/ERROR pulse against an expected-event queue filled as the
//   stimulus is driven (kind, cycle, VALUE and LOCKED).
module tb_stickit_decode;

   logic        CLK;
   logic        RESET_N;
   logic [7:0]  S_OE;
   logic [7:0]  S_IN;
   logic [31:0] VALUE;
   logic        VALID;
   logic        ERROR;
   logic        LOCKED;

   stickit_decode #(.TIMEOUT_CYCLES(16)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .S_OE    (S_OE),
      .S_IN    (S_IN),
      .VALUE   (VALUE),
      .VALID   (VALID),
      .ERROR   (ERROR),
      .LOCKED  (LOCKED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [6:0] SEGTAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct {
      bit          is_valid;
      logic [31:0] value;
      int unsigned cyc;
   } ev_t;

   ev_t         sb [$];
   ev_t         ev;
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_errors;
   logic [31:0] good_val;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard side: compare each pulse with the oldest expected event
   always @(negedge CLK) begin
      if (RESET_N === 1'b1) begin
         if (VALID || ERROR) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_pulse", 32'({VALID, ERROR}), 32'd0);
            end else begin
               ev = sb.pop_front();
               check_eq("pulse_kind", 32'({VALID, ERROR}), ev.is_valid ? 32'd2 : 32'd1);
               check_eq("pulse_cycle", cyc, ev.cyc);
               check_eq("value", VALUE, ev.value);
               check_eq("locked", 32'(LOCKED), 32'(ev.is_valid));
            end
         end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            ev = sb.pop_front();
            check_eq("missing_pulse", 32'({VALID, ERROR}), ev.is_valid ? 32'd2 : 32'd1);
         end
      end
   end

   task automatic tick(input logic [7:0] oe, input logic [7:0] iv);
      S_OE = oe;
      S_IN = iv;
      @(posedge CLK);
      #1;
   endtask

   task automatic blank(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick(8'h00, 8'h00);
   endtask

   task automatic drive_seg(input int unsigned k, input logic [6:0] seg);
      logic [7:0]  oe;
      logic [7:0]  iv;
      int unsigned j;
      oe = '0;
      iv = '0;
      oe[k[2:0]] = 1'b1;
      iv[k[2:0]] = 1'b1;
      j = 0;
      for (int unsigned l = 0; l < 8; l++) begin
         if (l != k) begin
            if (seg[j[2:0]]) oe[l[2:0]] = 1'b1;
            j++;
         end
      end
      tick(oe, iv);
   endtask

   task automatic drive_digit(input int unsigned k, input logic [3:0] nib);
      drive_seg(k, SEGTAB[nib]);
   endtask

   task automatic push_valid(input logic [31:0] v, input int unsigned at);
      ev_t e;
      e.is_valid = 1'b1;
      e.value    = v;
      e.cyc      = at;
      sb.push_back(e);
      good_val = v;
   endtask

   task automatic push_error(input int unsigned at);
      ev_t e;
      e.is_valid = 1'b0;
      e.value    = good_val;
      e.cyc      = at;
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [31:0] v);
      for (int unsigned k = 0; k < 8; k++) begin
         if (k == 7) push_valid(v, cyc + 2);
         drive_digit(k, v[4*k +: 4]);
      end
      blank(3);
   endtask

   task automatic send_digits(input logic [31:0] v, input int unsigned first, input int unsigned last);
      for (int unsigned k = first; k <= last; k++) drive_digit(k, v[4*k +: 4]);
   endtask

   logic [31:0] fv;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      good_val = '0;
      cyc      = 0;
      RESET_N  = 1'b0;
      S_OE     = '0;
      S_IN     = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_value", VALUE, 32'd0);
      check_eq("rst_valid", 32'(VALID), 32'd0);
      check_eq("rst_error", 32'(ERROR), 32'd0);
      check_eq("rst_locked", 32'(LOCKED), 32'd0);
      RESET_N = 1'b1;
      blank(2);

      // HUNT ignores bus errors, code errors and non-zero digits silently
      tick(8'h11, 8'h11);
      drive_digit(3, 4'h4);
      drive_seg(0, 7'h00);
      drive_digit(5, 4'h9);
      blank(3);

      // nominal scan
      send_frame(32'h1234_5678);

      // slow scan: each digit held four clocks, blanks between digits
      fv = 32'hDEAD_BEEF;
      for (int unsigned k = 0; k < 8; k++) begin
         if (k > 0) blank(1);
         for (int unsigned r = 0; r < 4; r++) begin
            if (k == 7 && r == 0) push_valid(fv, cyc + 2);
            drive_digit(k, fv[4*k +: 4]);
         end
      end
      blank(3);

      // bad segment code on digit 3; trailing digits must not restart
      fv = 32'hA5A5_A5A5;
      send_digits(fv, 0, 2);
      push_error(cyc + 2);
      drive_seg(3, 7'h00);
      send_digits(fv, 4, 7);
      blank(3);
      send_frame(32'h0F1E_2D3C);

      // two HIGH lines mid-frame
      send_digits(32'h7777_7777, 0, 1);
      push_error(cyc + 2);
      tick(8'h44, 8'h44);
      blank(3);
      send_frame(32'h9ABC_DEF0);

      // digit 5 skipped
      fv = 32'h3141_5926;
      send_digits(fv, 0, 4);
      push_error(cyc + 2);
      drive_digit(6, fv[27:24]);
      drive_digit(7, fv[31:28]);
      blank(3);
      send_frame(32'h2718_2818);

      // timeout after digit 2, then HUNT ignores the rest of that frame
      fv = 32'h5555_AAAA;
      send_digits(fv, 0, 1);
      push_error(cyc + 2 + 16);
      drive_digit(2, fv[11:8]);
      blank(24);
      send_digits(fv, 3, 7);
      blank(3);
      send_frame(32'h0BAD_CAFE);

      // reset during digit 4
      fv = 32'h1111_1111;
      send_digits(fv, 0, 3);
      S_OE = 8'h10;
      S_IN = 8'h10;
      RESET_N = 1'b0;
      good_val = '0;
      #2;
      check_eq("midrst_value", VALUE, 32'd0);
      check_eq("midrst_valid", 32'(VALID), 32'd0);
      check_eq("midrst_error", 32'(ERROR), 32'd0);
      check_eq("midrst_locked", 32'(LOCKED), 32'd0);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      send_digits(fv, 5, 7);
      blank(3);
      send_frame(32'hCAFE_F00D);

      // every nibble on every digit position
      for (int unsigned j = 0; j < 16; j++) begin
         fv = '0;
         for (int unsigned k = 0; k < 8; k++) fv[4*k +: 4] = 4'(j + k);
         send_frame(fv);
      end

      blank(30);
      check_eq("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stickit_decode.md
STICKIT_DECODE -- requirements
Module: stickit_decode

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: the number of idle clocks after which an open frame is abandoned.
REQ-003 CLK  in  1  sample clock; the same domain as the scan clock of the charlieplex driver.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 S_OE  in  8  per-line drive enable observed on the charlieplex bus; 0 means the line is undriven (Z).
REQ-006 S_IN  in  8  per-line driven level; it is meaningful only where S_OE is 1.
REQ-007 VALUE  out  32  last complete decoded frame; digit k occupies VALUE[4k+3:4k].
REQ-008 VALID  out  1  one-cycle pulse marking the cycle in which VALUE updates.
REQ-009 ERROR  out  1  one-cycle pulse marking the cycle in which a frame is discarded.
REQ-010 LOCKED  out  1  high after a successful frame; cleared by an error, a timeout or reset.

Function
REQ-011 S_OE and S_IN SHALL be registered once before any decode.
REQ-012 Line classification SHALL be: HIGH = OE=1 and IN=1; LOW = OE=1 and IN=0; Z = OE=0.
REQ-013 Select rule:
  - exactly one HIGH line at index k gives a digit sample for digit k;
  - no HIGH line is blanking and SHALL be ignored;
  - two or more HIGH lines is a bus error.
REQ-014 Segment extraction:
  - the 7 non-select lines, taken in ascending line order, form seg[0..6];
  - seg bit = 1 when the line is LOW (segment lit) and 0 when it is Z;
  - a LOW select line cannot occur and is covered by REQ-013.
REQ-015 Segment-to-nibble map SHALL be: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
REQ-016 Any other 7-bit segment code SHALL be a code error.
REQ-017 States SHALL be HUNT and COLLECT, together with a 3-bit expected-digit index E and an 8x4 shadow register.
REQ-018 In HUNT:
  - a valid sample of digit 0 writes shadow[0], sets E=1 and enters COLLECT;
  - all other samples, and all bus/code errors, SHALL be ignored with no ERROR pulse.
REQ-019 In COLLECT, a valid sample with k==E writes shadow[k] and increments E.
REQ-020 In COLLECT, a valid sample with k==E-1 (the slow-scan repeat case) overwrites shadow[k] and leaves E unchanged.
REQ-021 In COLLECT, a valid sample with k==7==E SHALL, on the next edge:
  - load VALUE from the shadow register, with the new digit 7 included;
  - pulse VALID;
  - set LOCKED;
  - enter HUNT.
REQ-022 In COLLECT, any of the following SHALL pulse ERROR, clear LOCKED and enter HUNT, and the offending sample SHALL NOT start a new frame:
  - an out-of-order index;
  - a bus error;
  - a code error.
REQ-023 Idle counter:
  - it SHALL count COLLECT cycles without an accepted digit sample (REQ-019/020);
  - when it reaches TIMEOUT_CYCLES, the block SHALL pulse ERROR, clear LOCKED and enter HUNT;
  - it SHALL reset on every accepted sample and on entry to HUNT;
  - it SHALL saturate and never wrap.
REQ-024 VALUE SHALL hold between frames and SHALL NOT change on error or timeout.
REQ-025 Latency: the digit-7 sample presented before edge n SHALL give VALUE/VALID visible after edge n+1.
REQ-026 VALID and ERROR SHALL never be asserted in the same cycle; VALID takes priority on timeout coincidence, because an accepted sample resets the idle counter.

Reset
REQ-027 Asynchronous assertion SHALL force:
  - VALUE=0, VALID=0, ERROR=0, LOCKED=0;
  - state HUNT, E=0;
  - shadow=0, idle counter=0;
  - input registers: OE=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, and the next frame SHALL start from digit 0.
REQ-029 Release SHALL be synchronous to CLK, and the first sample SHALL be decoded one edge after release.

Verification
REQ-030 Nominal scan: drive digits 0..7 with nibbles 8,7,6,5,4,3,2,1 on consecutive clocks, as the driver encodes them -> VALUE=0x12345678, one VALID pulse two edges after digit 7, LOCKED=1.
REQ-031 Slow scan: hold each digit 4 clocks with value 0xDEADBEEF, interleaving blanking cycles (all OE=0) -> VALUE=0xDEADBEEF, exactly one VALID, no ERROR.
REQ-032 Corruption, a frame with each of three faults:
  - segment code 0x00 on digit 3 -> ERROR pulse, LOCKED=0, VALUE unchanged, then a full frame recovers;
  - two HIGH lines -> same response;
  - digit 5 skipped -> same response.
REQ-033 Timeout: with TIMEOUT_CYCLES=16, stop after digit 2 -> ERROR exactly 16 cycles after the last accepted sample, state HUNT.
REQ-034 Reset mid-frame: assert RESET_N low for 1 cycle during digit 4 -> all outputs zero immediately, then the next full frame with 0xCAFEF00D decodes correctly.
REQ-035 Exhaustive map: all 16 nibbles on every digit position -> VALUE matches bit-for-bit.
